// File: rtl/mem_port_arbiter.sv
// Shares one Avalon-style memory port between instruction fetch and data access.
// Round-robin on ties, waits out waitrequest, and a watchdog aborts hung transfers.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        stall,
  output logic        bus_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_D} state_t;

  state_t        state_q, state_d;
  logic          lastGrantD_q, lastGrantD_d;
  logic [31:0]   memAddr_q, memAddr_d;
  logic [31:0]   memWdata_q, memWdata_d;
  logic [3:0]    memBe_q, memBe_d;
  logic          memRd_q, memRd_d;
  logic          memWr_q, memWr_d;
  logic          busErr_q, busErr_d;
  logic [CW-1:0] waitCnt_q, waitCnt_d;

  logic ifPend, dPend, grantD, grantIf, inBus, timeout, done;

  always_comb begin
    ifPend  = if_req;
    dPend   = d_read | d_write;
    // Data wins a tie unless it was the previous winner.
    grantD  = dPend & (~ifPend | ~lastGrantD_q);
    grantIf = ifPend & ~grantD;
    inBus   = (state_q == BUS_IF) || (state_q == BUS_D);
    timeout = inBus & mem_waitrequest & (waitCnt_q == CW'(MAX_WAIT - 1));
    done    = inBus & (~mem_waitrequest | timeout);
  end

  always_comb begin
    state_d      = state_q;
    lastGrantD_d = lastGrantD_q;
    memAddr_d    = memAddr_q;
    memWdata_d   = memWdata_q;
    memBe_d      = memBe_q;
    memRd_d      = memRd_q;
    memWr_d      = memWr_q;
    busErr_d     = busErr_q;
    waitCnt_d    = waitCnt_q;
    case (state_q)
      IDLE: begin
        if (grantD) begin
          state_d      = BUS_D;
          lastGrantD_d = 1'b1;
          memAddr_d    = d_addr;
          memWr_d      = d_write;
          memRd_d      = ~d_write;
          memWdata_d   = d_write ? d_wdata : 32'h0;
          memBe_d      = d_write ? d_byteenable : 4'hF;
          waitCnt_d    = '0;
          if (d_read && d_write) busErr_d = 1'b1;
        end else if (grantIf) begin
          state_d      = BUS_IF;
          lastGrantD_d = 1'b0;
          memAddr_d    = if_addr;
          memRd_d      = 1'b1;
          memWr_d      = 1'b0;
          memWdata_d   = 32'h0;
          memBe_d      = 4'hF;
          waitCnt_d    = '0;
        end
      end
      BUS_IF, BUS_D: begin
        if (done) begin
          state_d   = IDLE;
          memRd_d   = 1'b0;
          memWr_d   = 1'b0;
          waitCnt_d = '0;
          if (timeout) busErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lastGrantD_q <= 1'b0;
      memAddr_q    <= 32'h0;
      memWdata_q   <= 32'h0;
      memBe_q      <= 4'h0;
      memRd_q      <= 1'b0;
      memWr_q      <= 1'b0;
      busErr_q     <= 1'b0;
      waitCnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      lastGrantD_q <= lastGrantD_d;
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
      memBe_q      <= memBe_d;
      memRd_q      <= memRd_d;
      memWr_q      <= memWr_d;
      busErr_q     <= busErr_d;
      waitCnt_q    <= waitCnt_d;
    end
  end

  // A watchdog abort returns zero data rather than whatever is on the bus.
  assign if_ack         = (state_q == BUS_IF) & done;
  assign d_ack          = (state_q == BUS_D) & done;
  assign if_rdata       = (if_ack & ~timeout) ? mem_readdata : 32'h0;
  assign d_rdata        = (d_ack & memRd_q & ~timeout) ? mem_readdata : 32'h0;
  assign mem_address    = memAddr_q;
  assign mem_read       = memRd_q;
  assign mem_write      = memWr_q;
  assign mem_writedata  = memWdata_q;
  assign mem_byteenable = memBe_q;
  assign bus_err        = busErr_q;
  assign stall          = (if_req & ~if_ack) | ((d_read | d_write) & ~d_ack);

endmodule
